// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the two-source AXI-Stream arbiter.
package axis_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam int ZW = 256;

    function automatic logic [ZW-1:0] zext(
        input logic [ZW-1:0] d,
        input int            w
    );
        logic [ZW-1:0] r;
        r = '0;
        for (int i = 0; i < ZW; i++) begin
            if (i < w) r[i] = d[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Single-stage AXIS output register; loads when empty or when the sink takes the held beat.
module axis_reg_slice #(
    parameter int W = 33
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_ld
);

    logic         r_valid;
    logic [W-1:0] r_data;

    assign o_ld    = ~r_valid | i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_ld) begin
            r_valid <= i_valid;
            if (i_valid) r_data <= i_data;
        end
    end

endmodule

// File: rtl/axis_stream_arbiter.sv
// Round-robin burst arbiter merging two AXIS sources onto one tagged output.
module axis_stream_arbiter
    import axis_arb_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH_IN  = 16,
    parameter int AXIS_TDATA_WIDTH_OUT = 32,
    parameter int BURST_LEN            = 4
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic                            S0_AXIS_tvalid,
    input  logic [AXIS_TDATA_WIDTH_IN-1:0]  S0_AXIS_tdata,
    output logic                            S0_AXIS_tready,
    input  logic                            S1_AXIS_tvalid,
    input  logic [AXIS_TDATA_WIDTH_IN-1:0]  S1_AXIS_tdata,
    output logic                            S1_AXIS_tready,
    input  logic                            M_AXIS_tready,
    output logic                            M_AXIS_tvalid,
    output logic [AXIS_TDATA_WIDTH_OUT-1:0] M_AXIS_tdata,
    output logic                            M_AXIS_tid,
    output logic [1:0]                      grant
);

    localparam int IW = AXIS_TDATA_WIDTH_IN;
    localparam int OW = AXIS_TDATA_WIDTH_OUT;
    localparam int CW = $clog2(BURST_LEN) + 1;

    if (IW > OW) begin : g_width_err
        $error("axis_stream_arbiter: input width exceeds output width");
    end
    if (BURST_LEN < 1) begin : g_burst_err
        $error("axis_stream_arbiter: BURST_LEN must be at least 1");
    end

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_last;
    logic [1:0]    r_grant;

    logic          w_ld;
    logic          w_sel1;
    logic          w_src_v;
    logic          w_acc;
    logic          w_pick0;
    logic          w_pick1;
    logic          w_burst_end;
    logic [IW-1:0] w_src_d;
    logic [OW-1:0] w_ext;
    logic [OW:0]   w_out;

    assign w_sel1  = (r_state == GRANT1);
    assign w_src_v = w_sel1 ? S1_AXIS_tvalid : S0_AXIS_tvalid;
    assign w_src_d = w_sel1 ? S1_AXIS_tdata : S0_AXIS_tdata;

    assign S0_AXIS_tready = (r_state == GRANT0) & w_ld;
    assign S1_AXIS_tready = w_sel1 & w_ld;

    assign w_acc = (S0_AXIS_tvalid & S0_AXIS_tready)
                 | (S1_AXIS_tvalid & S1_AXIS_tready);

    // Source 0 wins a tie only when source 1 was served last.
    assign w_pick0 = S0_AXIS_tvalid & (r_last | ~S1_AXIS_tvalid);
    assign w_pick1 = S1_AXIS_tvalid & ~w_pick0;

    assign w_burst_end = (r_cnt == CW'(BURST_LEN - 1));
    assign w_ext       = OW'(zext(ZW'(w_src_d), IW));

    axis_reg_slice #(
        .W (OW + 1)
    ) u_out (
        .aclk    (aclk),
        .aresetn (aresetn),
        .i_valid (w_acc),
        .i_data  ({w_sel1, w_ext}),
        .i_ready (M_AXIS_tready),
        .o_valid (M_AXIS_tvalid),
        .o_data  (w_out),
        .o_ld    (w_ld)
    );

    assign M_AXIS_tid   = w_out[OW];
    assign M_AXIS_tdata = w_out[OW-1:0];
    assign grant        = r_grant;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_last  <= 1'b1;
            r_grant <= 2'b00;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_pick0) begin
                        r_state <= GRANT0;
                        r_grant <= 2'b01;
                        r_last  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (w_pick1) begin
                        r_state <= GRANT1;
                        r_grant <= 2'b10;
                        r_last  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                GRANT0, GRANT1: begin
                    if (w_acc) begin
                        r_cnt <= r_cnt + CW'(1);
                        if (w_burst_end) begin
                            r_state <= IDLE;
                            r_grant <= 2'b00;
                        end
                    end else if (!w_src_v) begin
                        r_state <= IDLE;
                        r_grant <= 2'b00;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_stream_arbiter.sv
// Directed bench for axis_stream_arbiter with a transaction-level reference model.
module tb_axis_stream_arbiter;

    localparam int BL = 4;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        S0_AXIS_tvalid;
    logic [15:0] S0_AXIS_tdata;
    logic        S0_AXIS_tready;
    logic        S1_AXIS_tvalid;
    logic [15:0] S1_AXIS_tdata;
    logic        S1_AXIS_tready;
    logic        M_AXIS_tready = 1'b0;
    logic        M_AXIS_tvalid;
    logic [31:0] M_AXIS_tdata;
    logic        M_AXIS_tid;
    logic [1:0]  grant;

    always #5 aclk = ~aclk;

    axis_stream_arbiter #(
        .AXIS_TDATA_WIDTH_IN  (16),
        .AXIS_TDATA_WIDTH_OUT (32),
        .BURST_LEN            (BL)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .S0_AXIS_tvalid (S0_AXIS_tvalid),
        .S0_AXIS_tdata  (S0_AXIS_tdata),
        .S0_AXIS_tready (S0_AXIS_tready),
        .S1_AXIS_tvalid (S1_AXIS_tvalid),
        .S1_AXIS_tdata  (S1_AXIS_tdata),
        .S1_AXIS_tready (S1_AXIS_tready),
        .M_AXIS_tready  (M_AXIS_tready),
        .M_AXIS_tvalid  (M_AXIS_tvalid),
        .M_AXIS_tdata   (M_AXIS_tdata),
        .M_AXIS_tid     (M_AXIS_tid),
        .grant          (grant)
    );

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [63:0] a,
                       input logic [63:0] e);
        n_tot++;
        if (a !== e)
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, a, e, cyc);
        else
            n_pass++;
    endtask

    // Sources: each emits base, base+1, ... for lim beats.
    logic        s_on  [2] = '{1'b0, 1'b0};
    logic [15:0] s_base[2] = '{16'h0, 16'h0};
    int          s_off [2] = '{0, 0};
    int          s_lim [2] = '{0, 0};
    int          s_acc [2] = '{0, 0};

    assign S0_AXIS_tvalid = s_on[0] && (s_acc[0] - s_off[0]) < s_lim[0];
    assign S1_AXIS_tvalid = s_on[1] && (s_acc[1] - s_off[1]) < s_lim[1];
    assign S0_AXIS_tdata  = s_base[0] + 16'(s_acc[0] - s_off[0]);
    assign S1_AXIS_tdata  = s_base[1] + 16'(s_acc[1] - s_off[1]);

    always @(posedge aclk) begin
        cyc <= cyc + 1;
        if (S0_AXIS_tvalid && S0_AXIS_tready) s_acc[0] <= s_acc[0] + 1;
        if (S1_AXIS_tvalid && S1_AXIS_tready) s_acc[1] <= s_acc[1] + 1;
    end

    // Reference model: owner -1 means nobody holds the output.
    int          m_own;
    int          m_taken;
    int          m_last;
    logic        m_ov;
    logic [31:0] m_od;
    logic        m_oid;
    logic        m_ld;
    logic        m_sv[2];
    logic [15:0] m_sd[2];
    int          m_pref;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_own   = -1;
            m_taken = 0;
            m_last  = 1;
            m_ov    = 1'b0;
            m_od    = 32'h0;
            m_oid   = 1'b0;
        end else begin
            m_sv[0] = S0_AXIS_tvalid;
            m_sv[1] = S1_AXIS_tvalid;
            m_sd[0] = S0_AXIS_tdata;
            m_sd[1] = S1_AXIS_tdata;
            m_ld = !m_ov || M_AXIS_tready;
            if (m_own < 0) begin
                if (m_ld) m_ov = 1'b0;
                m_pref = 1 - m_last;
                if (m_sv[m_pref]) m_own = m_pref;
                else if (m_sv[1 - m_pref]) m_own = 1 - m_pref;
                if (m_own >= 0) begin
                    m_last  = m_own;
                    m_taken = 0;
                end
            end else if (m_sv[m_own] && m_ld) begin
                m_ov  = 1'b1;
                m_od  = {16'h0, m_sd[m_own]};
                m_oid = m_own[0];
                m_taken++;
                if (m_taken == BL) m_own = -1;
            end else begin
                if (m_ld) m_ov = 1'b0;
                if (!m_sv[m_own]) m_own = -1;
            end
        end
    end

    function automatic logic [1:0] m_grant();
        return (m_own == 0) ? 2'b01 : (m_own == 1) ? 2'b10 : 2'b00;
    endfunction

    always @(negedge aclk) begin
        chk("cmp_tvalid", M_AXIS_tvalid, m_ov);
        if (m_ov) begin
            chk("cmp_tdata", M_AXIS_tdata, m_od);
            chk("cmp_tid", M_AXIS_tid, m_oid);
        end
        chk("cmp_grant", grant, m_grant());
        chk("cmp_s0_ready", S0_AXIS_tready,
            m_own == 0 && (!m_ov || M_AXIS_tready));
        chk("cmp_s1_ready", S1_AXIS_tready,
            m_own == 1 && (!m_ov || M_AXIS_tready));
    end

    typedef struct {
        logic [31:0] d;
        logic        id;
        int          c;
    } beat_t;
    beat_t log_q[$];

    always @(negedge aclk) begin
        if (aresetn && M_AXIS_tvalid && M_AXIS_tready)
            log_q.push_back('{M_AXIS_tdata, M_AXIS_tid, cyc});
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic start(input int k, input logic [15:0] b, input int lim);
        s_base[k] = b;
        s_off[k]  = s_acc[k];
        s_lim[k]  = lim;
        s_on[k]   = 1'b1;
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_tvalid"}, M_AXIS_tvalid, 0);
        chk({nm, "_tdata"}, M_AXIS_tdata, 0);
        chk({nm, "_tid"}, M_AXIS_tid, 0);
        chk({nm, "_grant"}, grant, 0);
        chk({nm, "_rdy0"}, S0_AXIS_tready, 0);
        chk({nm, "_rdy1"}, S1_AXIS_tready, 0);
    endtask

    task automatic rst_pulse(input string nm, input bit keep);
        cycles(1);
        if (!keep) begin
            s_on[0] = 1'b0;
            s_on[1] = 1'b0;
        end
        aresetn = 1'b0;
        #1;
        check_zero(nm);
        cycles(1);
        aresetn = 1'b1;
        log_q.delete();
    endtask

    task automatic chk_beat(input string nm, input int i,
                            input logic [31:0] d, input logic id);
        if (i < log_q.size()) begin
            chk({nm, "_data"}, log_q[i].d, d);
            chk({nm, "_tid"}, log_q[i].id, id);
        end else begin
            chk({nm, "_present"}, 0, 1);
        end
    endtask

    task automatic chk_gap(input string nm, input int i, input int g);
        if (i < log_q.size())
            chk(nm, log_q[i].c - log_q[i-1].c, g);
        else
            chk({nm, "_present"}, 0, 1);
    endtask

    initial begin
        logic [15:0] b;
        bit          got;
        cycles(3);
        check_zero("reset");
        aresetn = 1'b1;
        cycles(1);

        // Single source, 8 beats
        M_AXIS_tready = 1'b1;
        start(0, 16'h0001, 8);
        cycles(20);
        chk("t2_count", log_q.size(), 8);
        for (int i = 0; i < 8; i++)
            chk_beat("t2_beat", i, 32'(i + 1), 1'b0);
        for (int i = 1; i < 8; i++)
            chk_gap("t2_gap", i, (i == 4) ? 2 : 1);
        rst_pulse("t2_rst", 0);

        // Both sources saturated
        start(0, 16'hAAA0, 1000);
        start(1, 16'hBBB0, 1000);
        cycles(30);
        for (int i = 0; i < 16; i++) begin
            b = ((i / 4) % 2 == 0) ? 16'hAAA0 : 16'hBBB0;
            b = b + 16'((i / 8) * 4 + i % 4);
            chk_beat("t3_beat", i, {16'h0, b}, 1'((i / 4) % 2));
        end
        for (int i = 1; i < 16; i++)
            chk_gap("t3_gap", i, (i % 4 == 0) ? 2 : 1);

        // Reset mid-stream, sources still valid
        rst_pulse("t1_rst", 1);
        got = 0;
        for (int i = 0; i < 5 && !got; i++) begin
            @(negedge aclk);
            if (grant != 2'b00) got = 1;
        end
        chk("t1_first_grant", grant, 2'b01);
        rst_pulse("t1_rst2", 0);

        // Backpressure mid-burst
        start(0, 16'h0100, 8);
        cycles(3);
        M_AXIS_tready = 1'b0;
        cycles(1);
        chk("t4_stall_valid", M_AXIS_tvalid, 1);
        cycles(2);
        M_AXIS_tready = 1'b1;
        cycles(20);
        chk("t4_count", log_q.size(), 8);
        for (int i = 0; i < 8; i++)
            chk_beat("t4_beat", i, 32'h100 + 32'(i), 1'b0);
        rst_pulse("t4_rst", 0);

        // S1 runs dry after 2 beats while S0 waits
        start(0, 16'hA000, 1000);
        start(1, 16'hB000, 2);
        cycles(20);
        for (int i = 0; i < 4; i++)
            chk_beat("t5_s0", i, 32'hA000 + 32'(i), 1'b0);
        chk_beat("t5_s1a", 4, 32'h0000B000, 1'b1);
        chk_beat("t5_s1b", 5, 32'h0000B001, 1'b1);
        chk_beat("t5_s0_next", 6, 32'h0000A004, 1'b0);
        rst_pulse("t5_rst", 0);

        // Zero extension
        start(0, 16'hFFFF, 1);
        cycles(6);
        chk("t6_count", log_q.size(), 1);
        chk_beat("t6_zext", 0, 32'h0000FFFF, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
